// File: rtl/subtrator_pkg.sv
// Shared types and constants for the bit-serial two's-complement subtractor.
package subtrator_pkg;

  localparam int LARGURA_PADRAO = 8;

  typedef enum logic {
    OCIOSO  = 1'b0,
    CALCULA = 1'b1
  } estado_t;

endpackage

// File: rtl/celula_subtratora.sv
// One-bit full-adder cell; subtraction comes from feeding it ~B with carry-in 1.
module celula_subtratora (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: Resultado = Entrada1 - Entrada2, one bit per cycle, LSB first.
// Define SUBTRATOR_SERIAL_FLAGS_EN to build the Overflow/Zero/Negativo flag registers.
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Inicio,
  input  logic signed [LARGURA-1:0] Entrada1,
  input  logic signed [LARGURA-1:0] Entrada2,
  output logic signed [LARGURA-1:0] Resultado,
  output logic                      Valido,
  output logic                      Ocupado,
  output logic                      Overflow,
  output logic                      Zero,
  output logic                      Negativo
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t            estado_q;
  logic [LARGURA-1:0] a_q;
  logic [LARGURA-1:0] b_q;
  logic [LARGURA-1:0] parcial_q;
  logic [LARGURA-1:0] resultado_q;
  logic [CW-1:0]      cont_q;
  logic               carry_q;
  logic               valido_q;

  logic               soma_d;
  logic               carry_d;
  logic [LARGURA-1:0] parcial_d;

`ifdef SUBTRATOR_SERIAL_FLAGS_EN
  logic overflow_q;
  logic zero_q;
  logic negativo_q;
`endif

  celula_subtratora u_celula (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (soma_d),
    .c_o (carry_d)
  );

  // New sum bit enters at the MSB, so after LARGURA steps bit 0 lands in position 0.
  assign parcial_d = {soma_d, parcial_q[LARGURA-1:1]};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q    <= OCIOSO;
      a_q         <= '0;
      b_q         <= '0;
      parcial_q   <= '0;
      resultado_q <= '0;
      cont_q      <= '0;
      carry_q     <= 1'b0;
      valido_q    <= 1'b0;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negativo_q  <= 1'b0;
`endif
    end else begin
      valido_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (Inicio) begin
            a_q      <= Entrada1;
            b_q      <= ~Entrada2;
            carry_q  <= 1'b1;
            cont_q   <= '0;
            estado_q <= CALCULA;
          end
        end
        CALCULA: begin
          a_q       <= a_q >> 1;
          b_q       <= b_q >> 1;
          carry_q   <= carry_d;
          parcial_q <= parcial_d;
          cont_q    <= cont_q + 1'b1;
          if (cont_q == ULTIMO) begin
            resultado_q <= parcial_d;
            valido_q    <= 1'b1;
            estado_q    <= OCIOSO;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
            // On the MSB step carry_q is the carry into the MSB, carry_d the carry out.
            overflow_q  <= carry_q ^ carry_d;
            zero_q      <= (parcial_d == '0);
            negativo_q  <= soma_d;
`endif
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign Resultado = resultado_q;
  assign Valido    = valido_q;
  assign Ocupado   = (estado_q == CALCULA);

`ifdef SUBTRATOR_SERIAL_FLAGS_EN
  assign Overflow = overflow_q;
  assign Zero     = zero_q;
  assign Negativo = negativo_q;
`else
  assign Overflow = 1'b0;
  assign Zero     = 1'b0;
  assign Negativo = 1'b0;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial: directed vectors push expectations, a monitor checks each Valido.
module tb_subtrator_serial;

  logic              Clock;
  logic              Reset_n;
  logic              Inicio;
  logic signed [7:0] Entrada1;
  logic signed [7:0] Entrada2;
  logic signed [7:0] Resultado;
  logic              Valido;
  logic              Ocupado;
  logic              Overflow;
  logic              Zero;
  logic              Negativo;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       zero;
    logic       neg;
    int         due;
    string      name;
  } esperado_t;

  esperado_t sb[$];
  int total = 0;
  int bad   = 0;
  int cycleCnt = 0;

  subtrator_serial #(.LARGURA(8)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Inicio    (Inicio),
    .Entrada1  (Entrada1),
    .Entrada2  (Entrada2),
    .Resultado (Resultado),
    .Valido    (Valido),
    .Ocupado   (Ocupado),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Negativo  (Negativo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input string name, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] res, input logic ovf, input logic zero,
                               input logic neg, input bit expectResult);
    esperado_t e;
    Entrada1 = e1;
    Entrada2 = e2;
    Inicio   = 1'b1;
    if (expectResult) begin
      e.res  = res;
`ifdef SUBTRATOR_SERIAL_FLAGS_EN
      e.ovf  = ovf;
      e.zero = zero;
      e.neg  = neg;
`else
      e.ovf  = 1'b0;
      e.zero = 1'b0;
      e.neg  = 1'b0;
`endif
      e.due  = cycleCnt + 9;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge Clock);
    Inicio = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every Valido pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Reset_n && Valido) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valido: got Resultado=%0h with no pending operation", Resultado);
      end else begin
        esperado_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_res"},   32'($unsigned(Resultado)), 32'(e.res));
        checkOutput({e.name, "_ovf"},   32'(Overflow), 32'(e.ovf));
        checkOutput({e.name, "_zero"},  32'(Zero),     32'(e.zero));
        checkOutput({e.name, "_neg"},   32'(Negativo), 32'(e.neg));
        checkOutput({e.name, "_cycle"}, 32'(cycleCnt), 32'(e.due));
        checkOutput({e.name, "_busy"},  32'(Ocupado),  32'd0);
      end
    end
  end

  initial begin : stimulus
    int busyCnt;
    bit seen;
    Reset_n  = 1'b0;
    Inicio   = 1'b0;
    Entrada1 = '0;
    Entrada2 = '0;
    waitCycles(2);
    checkOutput("rst_res",  32'($unsigned(Resultado)), 32'd0);
    checkOutput("rst_val",  32'(Valido),   32'd0);
    checkOutput("rst_busy", 32'(Ocupado),  32'd0);
    checkOutput("rst_ovf",  32'(Overflow), 32'd0);
    checkOutput("rst_zero", 32'(Zero),     32'd0);
    checkOutput("rst_neg",  32'(Negativo), 32'd0);
    Reset_n = 1'b1;
    waitCycles(2);

    applyStimulus("sub5m3", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sub5m3_busy_start", 32'(Ocupado), 32'd1);
    waitCycles(10);

    applyStimulus("sub3m5", 8'd3, 8'd5, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(10);

    applyStimulus("subMinm1", 8'h80, 8'd1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(10);

    applyStimulus("sub7m7", 8'd7, 8'd7, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(10);

    // A second Inicio while busy must neither restart nor alter the operands.
    applyStimulus("sub10m4", 8'd10, 8'd4, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1);
    busyCnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (Ocupado) busyCnt++;
      if (i == 2) begin
        Entrada1 = 8'd1;
        Entrada2 = 8'd1;
        Inicio   = 1'b1;
      end else begin
        Inicio   = 1'b0;
      end
      @(negedge Clock);
    end
    checkOutput("busy_len", 32'(busyCnt), 32'd8);
    waitCycles(2);

    // Reset mid-operation aborts with no Valido.
    applyStimulus("abort", 8'd20, 8'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    Reset_n = 1'b0;
    #1;
    checkOutput("abort_res",  32'($unsigned(Resultado)), 32'd0);
    checkOutput("abort_val",  32'(Valido),   32'd0);
    checkOutput("abort_busy", 32'(Ocupado),  32'd0);
    checkOutput("abort_ovf",  32'(Overflow), 32'd0);
    checkOutput("abort_zero", 32'(Zero),     32'd0);
    checkOutput("abort_neg",  32'(Negativo), 32'd0);
    waitCycles(2);
    Reset_n = 1'b1;
    waitCycles(12);
    checkOutput("abort_hold_res", 32'($unsigned(Resultado)), 32'd0);
    applyStimulus("sub9m2", 8'd9, 8'd2, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);

    // Back-to-back: Inicio asserted during the Valido cycle is accepted.
    applyStimulus("sub100mm28", 8'd100, 8'hE4, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (Valido) seen = 1'b1;
      else @(negedge Clock);
    end
    checkOutput("b2b_valido_seen", 32'(seen), 32'd1);
    if (seen) begin
      applyStimulus("sub2m3", 8'd2, 8'd3, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("b2b_busy", 32'(Ocupado), 32'd1);
    end
    waitCycles(12);
    checkOutput("hold_res", 32'($unsigned(Resultado)), 32'hFF);

    checkOutput("pending", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/subtrator_serial.md
SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 The block SHALL have parameter LARGURA, default 8, the operand and result width in bits.
REQ-002 Port Clock SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port Reset_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-004 Port Inicio SHALL be input, 1 bit: start request, sampled on the rising edge.
REQ-005 Port Entrada1 SHALL be input, signed LARGURA bits: minuend, sampled with Inicio.
REQ-006 Port Entrada2 SHALL be input, signed LARGURA bits: subtrahend, sampled with Inicio.
REQ-007 Port Resultado SHALL be output, signed LARGURA bits: registered Entrada1 - Entrada2.
REQ-008 Port Valido SHALL be output, 1 bit: one-cycle pulse marking a new Resultado.
REQ-009 Port Ocupado SHALL be output, 1 bit: high while a subtraction is in progress.
REQ-010 Ports Overflow, Zero and Negativo SHALL be outputs, 1 bit each: status flags of the last result.

Function
REQ-011 The FSM SHALL have states OCIOSO and CALCULA; Ocupado = (state == CALCULA).
REQ-012 Inicio SHALL be accepted only when Ocupado is low, including the cycle in which Valido is high.
REQ-013 Inicio SHALL be ignored while Ocupado is high; it SHALL NOT alter the operands or restart the operation.
REQ-014 On acceptance, the block SHALL latch Entrada1 into shift register A and ~Entrada2 into shift register B, set the carry flop to 1 and a bit counter to 0, and enter CALCULA.
REQ-015 Each CALCULA cycle SHALL compute one bit, LSB first: s = a0 ^ b0 ^ c and c' = majority(a0, b0, c); A and B shift right, and s enters the MSB of the partial-result register.
REQ-016 After exactly LARGURA CALCULA cycles, on the same edge, the block SHALL load Resultado from the partial register, assert Valido, and return to OCIOSO.
REQ-017 Latency SHALL be LARGURA cycles: for LARGURA = 8, Valido is high in the cycle after the 8th rising edge following the accepting edge.
REQ-018 Valido SHALL be high for exactly one cycle per accepted Inicio.
REQ-019 Resultado and the flags SHALL hold their values until the next completion.
REQ-020 Arithmetic SHALL wrap modulo 2^LARGURA (two's complement), with no saturation.
REQ-021 Overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 Zero SHALL be high when Resultado == 0.
REQ-023 Negativo SHALL equal Resultado[LARGURA-1].

Reset
REQ-024 Reset_n low SHALL immediately force the state to OCIOSO and clear Resultado, Valido, Ocupado, all flags, the shift registers, the carry flop and the counter to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no Valido pulse; the next Inicio after reset release SHALL operate normally.

Configuration
REQ-026 Macro SUBTRATOR_SERIAL_FLAGS_EN SHALL compile in the Overflow, Zero and Negativo logic.
REQ-027 With the macro defined, REQ-021 to REQ-023 SHALL apply.
REQ-028 Without the macro, the ports SHALL remain present, SHALL be tied to 0, and the flag registers SHALL be absent.

Structure
REQ-029 Package subtrator_pkg SHALL hold the state enumeration (OCIOSO, CALCULA) and the default width constant LARGURA_PADRAO = 8.
REQ-030 Sub-module celula_subtratora SHALL implement the combinational 1-bit full-adder cell (a, b, c -> s, c'), instantiated once.

Verification
REQ-031 Entrada1 = 5, Entrada2 = 3, Inicio pulsed -> Valido after 8 cycles, Resultado = 00000010; Overflow, Zero and Negativo all 0.
REQ-032 Entrada1 = 3, Entrada2 = 5 -> Resultado = 11111110 (-2), Negativo = 1, Overflow = 0.
REQ-033 Entrada1 = -128, Entrada2 = 1 -> Resultado = 01111111, Overflow = 1; also Entrada1 = 7, Entrada2 = 7 -> Resultado = 0, Zero = 1.
REQ-034 Inicio with 10, 4, then Inicio again at cycle 3 with 1, 1 -> a single Valido with Resultado = 6; Ocupado high for 8 cycles.
REQ-035 Inicio with 20, 5, then Reset_n low at cycle 4 -> all outputs 0 and no Valido; after release, Inicio with 9, 2 -> Resultado = 7.
REQ-036 Back-to-back case: Inicio held high in the Valido cycle with new operands (2, 3) -> accepted; second Valido 8 cycles later with Resultado = -1.
